// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data and occupancy count.
// Status outputs come from registered state only; no push/pop-to-status path.
module fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             push_ok, pop_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A push into a full FIFO is allowed when a pop frees the oldest slot on the same edge.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop_ok) begin
            rd_ptr_d  = next_ptr(rd_ptr_q);
            rd_data_d = mem_q[rd_ptr_q];
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments let a full-FIFO pop read the old word while the same slot is rewritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = rd_data_q;
    assign count   = count_q;

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed boundary cases plus random traffic,
// compared against a queue-based reference model.
module tb_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             push;
    logic [WIDTH-1:0] wr_data;
    logic             pop;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] m_rd;

    fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".rd_data"}, 32'(rd_data), 32'(m_rd));
        chk({tag, ".count"},   32'(count),   32'(model_q.size()));
        chk({tag, ".full"},    32'(full),    32'(model_q.size() == DEPTH));
        chk({tag, ".empty"},   32'(empty),   32'(model_q.size() == 0));
    endtask

    // One clock edge of stimulus; the model applies the FIFO rules to its own queue.
    task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic o, input string tag);
        int sz       = model_q.size();
        bit pop_acc  = o && (sz > 0);
        bit push_acc = p && ((sz < DEPTH) || o);
        push    = p;
        wr_data = d;
        pop     = o;
        @(posedge clk);
        #1;
        if (pop_acc)  m_rd = model_q.pop_front();
        if (push_acc) model_q.push_back(d);
        push = 1'b0;
        pop  = 1'b0;
        chk_state(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] last_in;
        rst_n   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        wr_data = '0;
        m_rd    = '0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk_state("reset");

        // Fill 1..8, then a 9th push while full must be ignored.
        for (int i = 1; i <= 9; i++) step(1'b1, WIDTH'(i), 1'b0, "fill");
        chk("fill.count_held", 32'(count), 32'(DEPTH));

        // Drain 8 words, then one extra pop must leave rd_data at 8.
        for (int i = 1; i <= 9; i++) step(1'b0, '0, 1'b1, "drain");
        chk("drain.rd_hold", 32'(rd_data), 32'h0008);

        // Wrap-around: 5 in/5 out, then 6 in/6 out.
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'($urandom), 1'b0, "wrap5_in");
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, "wrap5_out");
        for (int i = 0; i < 6; i++) step(1'b1, WIDTH'($urandom), 1'b0, "wrap6_in");
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, "wrap6_out");
        chk("wrap.count_zero", 32'(count), 32'h0);

        // Concurrent push/pop at full: oldest out, 0x00AA becomes the newest.
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'($urandom), 1'b0, "fill_rand");
        step(1'b1, 16'h00AA, 1'b1, "full_pushpop");
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, "drain_aa");
        chk("full_pushpop.last_word", 32'(rd_data), 32'h00AA);

        // Concurrent push/pop at empty: only the push lands, no fall-through.
        step(1'b1, 16'h1234, 1'b1, "empty_pushpop");
        chk("empty_pushpop.no_bypass", 32'(rd_data), 32'h00AA);
        step(1'b0, '0, 1'b1, "empty_pushpop_read");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            last_in = WIDTH'($urandom);
            step(1'($urandom), last_in, 1'($urandom), "random");
        end

        // Asynchronous reset with four entries stored.
        while (model_q.size() > 0) step(1'b0, '0, 1'b1, "pre_rst_drain");
        for (int i = 0; i < 4; i++) step(1'b1, WIDTH'($urandom), 1'b0, "pre_rst_fill");
        chk("pre_rst.count", 32'(count), 32'h4);
        #3;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        m_rd = '0;
        chk_state("mid_reset");
        #1;
        rst_n = 1'b1;
        step(1'b0, '0, 1'b1, "post_rst_pop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Synchronous single-clock FIFO buffer, parameterised in data width and depth.
- Decouples a producer (push/wr_data) from a consumer (pop/rd_data) within one clock domain.
- Reports full/empty status and an occupancy count.
- Used as a generic staging buffer between datapath stages.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- DEPTH, 8, number of storage entries (>=2; any integer, power of two not required).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  write request; accepted on a clk rising edge when not blocked (see Behaviour).
- wr_data  input  WIDTH  data written on an accepted push.
- pop  input  1  read request; accepted on a clk rising edge when FIFO is not empty.
- rd_data  output  WIDTH  registered read data, updated one edge after an accepted pop.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- count  output  $clog2(DEPTH+1)  current number of stored entries.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - write and read pointers = 0; count = 0; rd_data = 0; empty = 1; full = 0.
  - Storage array contents need not be cleared.
- Clocking: all updates on the clk rising edge while rst_n is high. full, empty and count are derived from registered state only, with no combinational path from push or pop.
- Push accepted (push_ok) when push=1 and either (full=0) or (full=1 and pop=1):
  - wr_data is written at the write pointer.
  - Write pointer advances by 1 and wraps from DEPTH-1 to 0.
- Push while full without pop: ignored. No write, no pointer move, no error flag.
- Pop accepted (pop_ok) when pop=1 and empty=0:
  - rd_data <= entry at the read pointer, visible after that same edge (1-cycle latency).
  - Read pointer advances by 1 with the same wrap rule.
- Pop while empty: ignored. rd_data holds its previous value. A push in the same cycle is still accepted.
- rd_data holds its last value whenever no pop is accepted.
- count update:
  - +1 on push_ok only.
  - -1 on pop_ok only.
  - Unchanged when both or neither are accepted.
- Simultaneous push and pop:
  - When full: both accepted; count stays DEPTH; the popped word is the oldest entry.
  - When empty: only the push is accepted; count becomes 1; rd_data is unchanged. No fall-through: the new word is not bypassed to rd_data.
  - Otherwise: both accepted; count is unchanged.
- Ordering: strict first-in first-out, including across pointer wrap-around.
- Reset asserted mid-operation: the FIFO returns immediately to the reset state and all stored data is discarded.

Test Plan:
- Reset: hold rst_n=0 then release -> empty=1, full=0, count=0, rd_data=0x0000.
- Fill (WIDTH=16, DEPTH=8): push 0x0001..0x0008 on 8 consecutive edges -> count 1..8; empty=0 after the 1st edge; full=1 after the 8th edge; a 9th push of 0x0009 is ignored and count stays 8.
- Drain: pop on 8 consecutive edges -> rd_data 0x0001..0x0008, one per edge; full=0 after the 1st pop; empty=1 after the 8th; a further pop leaves rd_data=0x0008.
- Wrap-around: push 5, pop 5, push 6, pop 6 -> data returned in exact FIFO order across the pointer wrap; count returns to 0.
- Concurrent at boundaries:
  - At full, push 0x00AA with pop -> oldest word is output, count stays 8, 0x00AA is read last.
  - At empty, push with pop -> count becomes 1 and rd_data is unchanged.
- Reset mid-stream: with count=4, pulse rst_n low between edges -> immediate empty=1, count=0, rd_data=0; a later pop is ignored.
